// File: rtl/edge_conv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the edge_conv_pipe gradient edge detector:
//   - mode encodings carried with each window
//   - 3x3 kernel coefficient tables (row-major, k=0 top-left, k=8 bottom-right)
//   - width helpers for gradient, square and energy words
// -----------------------------------------------------------------------------
package conv_pkg;

   // Per-window operating mode. 2'b11 is handled like MODE_BOTH.
   localparam logic [1:0] MODE_SOBEL   = 2'b00;
   localparam logic [1:0] MODE_PREWITT = 2'b01;
   localparam logic [1:0] MODE_BOTH    = 2'b10;

   // Kernel set selectors for conv_grad3x3.
   localparam int KERN_SOBEL   = 0;
   localparam int KERN_PREWITT = 1;

   localparam int SOBEL_GX   [9] = '{ 1,  0, -1,   2,  0, -2,   1,  0, -1};
   localparam int SOBEL_GY   [9] = '{ 1,  2,  1,   0,  0,  0,  -1, -2, -1};
   localparam int PREWITT_GX [9] = '{ 1,  0, -1,   1,  0, -1,   1,  0, -1};
   localparam int PREWITT_GY [9] = '{ 1,  1,  1,   0,  0,  0,  -1, -1, -1};

   // Signed gradient: |G| <= 4*(2^PIX_W-1) needs PIX_W+3 bits.
   function automatic int grad_w(input int pix_w);
      return pix_w + 3;
   endfunction

   // Unsigned square of one gradient.
   function automatic int sq_w(input int pix_w);
      return 2 * pix_w + 4;
   endfunction

   // Sum of up to four squares.
   function automatic int acc_w(input int pix_w);
      return 2 * pix_w + 6;
   endfunction

   // Coefficient lookup; axis_y=0 selects Gx, 1 selects Gy.
   function automatic int kern_coef(input int kern, input logic axis_y, input int k);
      if (kern == KERN_PREWITT) begin
         return axis_y ? PREWITT_GY[k] : PREWITT_GX[k];
      end
      return axis_y ? SOBEL_GY[k] : SOBEL_GX[k];
   endfunction

endpackage

// File: rtl/edge_conv_pipe_if.sv
// -----------------------------------------------------------------------------
// edge_conv_pipe_if
// Bundles the window input stream, the result output stream and the edge
// counter controls of edge_conv_pipe.
//
// Handshake rule (both streams): a transfer happens on a rising clock edge
// where valid && ready are both 1. The producer holds valid and its payload
// stable until that transfer; ready may change freely and, on the window
// side, is combinationally derived from downstream ready.
//
// Signals:
//   i_pixel_data / i_pixel_data_valid / o_pixel_data_ready : window stream
//   i_mode, i_threshold                                    : per-window controls
//   o_convolved_data / o_convolved_data_valid /
//   i_convolved_data_ready                                 : result stream
//   i_count_clr, o_edge_count                              : edge counter
// Modports: slave (the detector), master (the environment driving it).
// -----------------------------------------------------------------------------
interface edge_conv_pipe_if
   import conv_pkg::*;
#(
   parameter int PIX_W   = 8,
   parameter int COUNT_W = 16
);
   localparam int ACC_W = acc_w(PIX_W);

   logic [9*PIX_W-1:0] i_pixel_data;
   logic               i_pixel_data_valid;
   logic               o_pixel_data_ready;
   logic [1:0]         i_mode;
   logic [ACC_W-1:0]   i_threshold;
   logic [PIX_W-1:0]   o_convolved_data;
   logic               o_convolved_data_valid;
   logic               i_convolved_data_ready;
   logic               i_count_clr;
   logic [COUNT_W-1:0] o_edge_count;

   modport slave (
      input  i_pixel_data, i_pixel_data_valid, i_mode, i_threshold,
      input  i_convolved_data_ready, i_count_clr,
      output o_pixel_data_ready, o_convolved_data, o_convolved_data_valid,
      output o_edge_count
   );

   modport master (
      output i_pixel_data, i_pixel_data_valid, i_mode, i_threshold,
      output i_convolved_data_ready, i_count_clr,
      input  o_pixel_data_ready, o_convolved_data, o_convolved_data_valid,
      input  o_edge_count
   );

endinterface

// File: rtl/edge_conv_pipe_grad3x3.sv
// -----------------------------------------------------------------------------
// conv_grad3x3
// Registered (Gx, Gy) gradient pair of one 3x3 window for a kernel set
// chosen by the KERN parameter (conv_pkg::KERN_SOBEL / KERN_PREWITT).
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : load enable (stage advance)
//   i_window       : 9 unsigned pixels, pixel k at [k*PIX_W +: PIX_W]
//   o_gx, o_gy     : signed gradients, PIX_W+3 bits
// -----------------------------------------------------------------------------
module conv_grad3x3
   import conv_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int KERN  = KERN_SOBEL
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_en,
   input  logic [9*PIX_W-1:0]              i_window,
   output logic signed [grad_w(PIX_W)-1:0] o_gx,
   output logic signed [grad_w(PIX_W)-1:0] o_gy
);
   localparam int GW = grad_w(PIX_W);

   logic signed [GW-1:0] w_pix;
   logic signed [GW-1:0] w_gx;
   logic signed [GW-1:0] w_gy;

   // Coefficients are elaboration constants, so the multiplies fold into
   // shifts/adds; partial sums never exceed the final gradient range.
   always_comb begin
      w_pix = '0;
      w_gx  = '0;
      w_gy  = '0;
      for (int k = 0; k < 9; k++) begin
         w_pix = $signed({{(GW-PIX_W){1'b0}}, i_window[k*PIX_W +: PIX_W]});
         w_gx  = w_gx + GW'(kern_coef(KERN, 1'b0, k)) * w_pix;
         w_gy  = w_gy + GW'(kern_coef(KERN, 1'b1, k)) * w_pix;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_gx <= '0;
         o_gy <= '0;
      end else if (i_en) begin
         o_gx <= w_gx;
         o_gy <= w_gy;
      end
   end

endmodule

// File: rtl/edge_conv_pipe.sv
// -----------------------------------------------------------------------------
// edge_conv_pipe
// 4-stage 3x3 gradient edge detector with valid/ready flow control.
//   S1: window + sampled mode/threshold
//   S2: Sobel and Prewitt gradients (two conv_grad3x3 instances)
//   S3: squares and mode-selected energy sum
//   S4: threshold compare, output pixel and edge flag
// Each stage advances when it is empty or the next stage advances, so
// bubbles collapse and up to four windows are held during a stall.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : edge_conv_pipe_if.slave (streams, controls, counter)
// Parameters: PIX_W, COUNT_W, MAG_SHIFT (magnitude output only).
// Build option: define EDGE_MAG_OUT_EN to output min(E >> MAG_SHIFT, max
// pixel) instead of the binary edge pixel.
// -----------------------------------------------------------------------------
module edge_conv_pipe
   import conv_pkg::*;
#(
   parameter int PIX_W     = 8,
   parameter int COUNT_W   = 16,
   parameter int MAG_SHIFT = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   edge_conv_pipe_if.slave bus
);
   localparam int GW    = grad_w(PIX_W);
   localparam int ACC_W = acc_w(PIX_W);

   // Stage advance enables, back to front.
   logic w_en1, w_en2, w_en3, w_en4;

   logic               r1_valid;
   logic [9*PIX_W-1:0] r1_window;
   logic [1:0]         r1_mode;
   logic [ACC_W-1:0]   r1_thr;

   logic               r2_valid;
   logic [1:0]         r2_mode;
   logic [ACC_W-1:0]   r2_thr;
   logic signed [GW-1:0] w_sob_gx, w_sob_gy, w_pre_gx, w_pre_gy;

   logic               r3_valid;
   logic [ACC_W-1:0]   r3_energy;
   logic [ACC_W-1:0]   r3_thr;
   logic [ACC_W-1:0]   w_energy;

   logic               r4_valid;
   logic [PIX_W-1:0]   r4_data;
   logic               r4_edge;
   logic               w_edge;
   logic [PIX_W-1:0]   w_out_pix;

   logic [COUNT_W-1:0] r_edge_count;

   assign w_en4 = !r4_valid || bus.i_convolved_data_ready;
   assign w_en3 = !r3_valid || w_en4;
   assign w_en2 = !r2_valid || w_en3;
   assign w_en1 = !r1_valid || w_en2;

   // ---------------- S1 ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r1_valid  <= 1'b0;
         r1_window <= '0;
         r1_mode   <= MODE_SOBEL;
         r1_thr    <= '0;
      end else if (w_en1) begin
         r1_valid <= bus.i_pixel_data_valid;
         if (bus.i_pixel_data_valid) begin
            r1_window <= bus.i_pixel_data;
            r1_mode   <= bus.i_mode;
            r1_thr    <= bus.i_threshold;
         end
      end
   end

   // ---------------- S2 ----------------
   conv_grad3x3 #(.PIX_W(PIX_W), .KERN(KERN_SOBEL)) u_grad_sobel (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (w_en2 && r1_valid),
      .i_window (r1_window),
      .o_gx     (w_sob_gx),
      .o_gy     (w_sob_gy)
   );

   conv_grad3x3 #(.PIX_W(PIX_W), .KERN(KERN_PREWITT)) u_grad_prewitt (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (w_en2 && r1_valid),
      .i_window (r1_window),
      .o_gx     (w_pre_gx),
      .o_gy     (w_pre_gy)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r2_valid <= 1'b0;
         r2_mode  <= MODE_SOBEL;
         r2_thr   <= '0;
      end else if (w_en2) begin
         r2_valid <= r1_valid;
         if (r1_valid) begin
            r2_mode <= r1_mode;
            r2_thr  <= r1_thr;
         end
      end
   end

   // ---------------- S3 ----------------
   // Squares are computed at ACC_W (= 2*GW) so the signed product is exact;
   // each result fits in 2*PIX_W+4 bits and the four-term sum in ACC_W.
   function automatic logic [ACC_W-1:0] square(input logic signed [GW-1:0] g);
      logic signed [ACC_W-1:0] ext;
      ext = ACC_W'(g);
      return ext * ext;
   endfunction

   always_comb begin
      w_energy = '0;
      case (r2_mode)
         MODE_SOBEL:   w_energy = square(w_sob_gx) + square(w_sob_gy);
         MODE_PREWITT: w_energy = square(w_pre_gx) + square(w_pre_gy);
         // MODE_BOTH and the reserved 2'b11
         default:      w_energy = square(w_sob_gx) + square(w_sob_gy)
                                + square(w_pre_gx) + square(w_pre_gy);
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r3_valid  <= 1'b0;
         r3_energy <= '0;
         r3_thr    <= '0;
      end else if (w_en3) begin
         r3_valid <= r2_valid;
         if (r2_valid) begin
            r3_energy <= w_energy;
            r3_thr    <= r2_thr;
         end
      end
   end

   // ---------------- S4 ----------------
   assign w_edge = (r3_energy > r3_thr);

`ifdef EDGE_MAG_OUT_EN
   logic [ACC_W-1:0] w_mag;
   assign w_mag     = r3_energy >> MAG_SHIFT;
   assign w_out_pix = (w_mag > ACC_W'((1 << PIX_W) - 1)) ? {PIX_W{1'b1}}
                                                          : w_mag[PIX_W-1:0];
`else
   assign w_out_pix = {PIX_W{w_edge}};
`endif

   // Data only loads with a valid window, so it stays put while stalled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r4_valid <= 1'b0;
         r4_data  <= '0;
         r4_edge  <= 1'b0;
      end else if (w_en4) begin
         r4_valid <= r3_valid;
         if (r3_valid) begin
            r4_data <= w_out_pix;
            r4_edge <= w_edge;
         end
      end
   end

   // ---------------- edge counter ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_edge_count <= '0;
      end else if (bus.i_count_clr) begin
         r_edge_count <= '0;
      end else if (r4_valid && bus.i_convolved_data_ready && r4_edge &&
                   (r_edge_count != {COUNT_W{1'b1}})) begin
         r_edge_count <= r_edge_count + 1'b1;
      end
   end

   assign bus.o_pixel_data_ready     = w_en1;
   assign bus.o_convolved_data       = r4_data;
   assign bus.o_convolved_data_valid = r4_valid;
   assign bus.o_edge_count           = r_edge_count;

endmodule

// File: tb/tb_edge_conv_pipe.sv
// -----------------------------------------------------------------------------
// tb_edge_conv_pipe
// Self-checking bench for edge_conv_pipe (COUNT_W=4 so saturation is cheap).
// Inputs change 1 time unit after the rising edge; outputs and handshakes
// are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_edge_conv_pipe;
   localparam int PIX_W   = 8;
   localparam int COUNT_W = 4;
   localparam int ACC_W   = 2*PIX_W + 6;
   localparam int W       = PIX_W + 1;   // {edge flag, output pixel}

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   edge_conv_pipe_if #(.PIX_W(PIX_W), .COUNT_W(COUNT_W)) bus ();

   edge_conv_pipe #(.PIX_W(PIX_W), .COUNT_W(COUNT_W), .MAG_SHIFT(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0]       exp_q[$];
   logic [COUNT_W-1:0] cnt_model = '0;
   int n_checks = 0;
   int n_errors = 0;
   int acc_cnt  = 0;
   bit rand_done;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int model_energy(input logic [9*PIX_W-1:0] w, input logic [1:0] m);
      int p[9];
      int sgx, sgy, pgx, pgy, es, ep;
      for (int k = 0; k < 9; k++) p[k] = int'(w[k*PIX_W +: PIX_W]);
      sgx = (p[0] + 2*p[3] + p[6]) - (p[2] + 2*p[5] + p[8]);
      sgy = (p[0] + 2*p[1] + p[2]) - (p[6] + 2*p[7] + p[8]);
      pgx = (p[0] + p[3] + p[6]) - (p[2] + p[5] + p[8]);
      pgy = (p[0] + p[1] + p[2]) - (p[6] + p[7] + p[8]);
      es  = sgx*sgx + sgy*sgy;
      ep  = pgx*pgx + pgy*pgy;
      case (m)
         2'b00:   return es;
         2'b01:   return ep;
         default: return es + ep;
      endcase
   endfunction

   function automatic logic [W-1:0] expect_of(input logic [9*PIX_W-1:0] w,
                                              input logic [1:0] m,
                                              input logic [ACC_W-1:0] t);
      int  e;
      logic edge_f;
      logic [PIX_W-1:0] pix;
      e      = model_energy(w, m);
      edge_f = (e > int'(t));
`ifdef EDGE_MAG_OUT_EN
      pix = ((e >> 8) > 255) ? 8'd255 : PIX_W'(e >> 8);
`else
      pix = edge_f ? 8'hFF : 8'h00;
`endif
      return {edge_f, pix};
   endfunction

   function automatic logic [9*PIX_W-1:0] win_flat(input int v);
      logic [9*PIX_W-1:0] w;
      for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = PIX_W'(v);
      return w;
   endfunction

   function automatic logic [9*PIX_W-1:0] win_col0(input int v);
      logic [9*PIX_W-1:0] w;
      w = '0;
      w[0*PIX_W +: PIX_W] = PIX_W'(v);
      w[3*PIX_W +: PIX_W] = PIX_W'(v);
      w[6*PIX_W +: PIX_W] = PIX_W'(v);
      return w;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one window and returns (at edge+1) once it has been accepted.
   task automatic send(input logic [9*PIX_W-1:0] w, input logic [1:0] m,
                       input logic [ACC_W-1:0] t);
      int guard = 0;
      bit done  = 0;
      bus.i_pixel_data       = w;
      bus.i_mode             = m;
      bus.i_threshold        = t;
      bus.i_pixel_data_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (bus.o_pixel_data_ready) begin
            exp_q.push_back(expect_of(w, m, t));
            acc_cnt++;
            done = 1;
         end else if (++guard > 200) begin
            check_eq("accept_timeout", 32'(bus.o_pixel_data_ready), 1);
            done = 1;
         end
         tick();
      end
      bus.i_pixel_data_valid = 1'b0;
   endtask

   // Random window with threshold placed at E-1, E or E+1.
   task automatic send_rand();
      logic [9*PIX_W-1:0] w;
      logic [1:0] m;
      int e, t;
      for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) w = win_flat($urandom_range(0, 255));
      m = 2'($urandom_range(0, 3));
      e = model_energy(w, m);
      t = e + int'($urandom_range(0, 2)) - 1;
      if (t < 0) t = 0;
      send(w, m, ACC_W'(t));
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 300) begin
         tick();
         guard++;
      end
      check_eq("drain", 32'(exp_q.size()), 0);
   endtask

   // Counts falling edges after acceptance until the result is valid.
   task automatic measure_latency(input string tag);
      int n = 0;
      bit seen = 0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (bus.o_convolved_data_valid) seen = 1;
      end
      check_eq(tag, 32'(n), 4);
      tick();
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic tx_edge;
      tx_edge = 1'b0;
      if (!rst_n) begin
         cnt_model = '0;
      end else begin
         check_eq("edge_count", 32'(bus.o_edge_count), 32'(cnt_model));
         if (bus.o_convolved_data_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_valid", 32'(bus.o_convolved_data_valid), 0);
            end else begin
               e = exp_q[0];
               check_eq("out_data", 32'(bus.o_convolved_data), 32'(e[PIX_W-1:0]));
               if (bus.i_convolved_data_ready) begin
                  void'(exp_q.pop_front());
                  tx_edge = e[PIX_W];
               end
            end
         end
         if (bus.i_count_clr) cnt_model = '0;
         else if (tx_edge && cnt_model != {COUNT_W{1'b1}}) cnt_model = cnt_model + 1'b1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      int acc0;
      int guard;
      bus.i_pixel_data           = '0;
      bus.i_pixel_data_valid     = 1'b0;
      bus.i_mode                 = 2'b00;
      bus.i_threshold            = ACC_W'(4000);
      bus.i_convolved_data_ready = 1'b1;
      bus.i_count_clr            = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid", 32'(bus.o_convolved_data_valid), 0);
      check_eq("rst_data",  32'(bus.o_convolved_data), 0);
      check_eq("rst_count", 32'(bus.o_edge_count), 0);
      check_eq("rst_ready", 32'(bus.o_pixel_data_ready), 1);
      rst_n = 1'b1;
      tick();

      // flat window: no edge, 4-cycle latency
      send(win_flat(100), 2'b10, ACC_W'(4000));
      measure_latency("latency_flat");
      drain();
      check_eq("flat_count", 32'(bus.o_edge_count), 0);

      // vertical edge in each mode
      send(win_col0(255), 2'b00, ACC_W'(4000));
      send(win_col0(255), 2'b01, ACC_W'(4000));
      send(win_col0(255), 2'b10, ACC_W'(4000));
      drain();
      check_eq("col_count", 32'(bus.o_edge_count), 3);

      // strict threshold boundary: E=200
      begin
         logic [9*PIX_W-1:0] w;
         w = '0;
         w[0 +: PIX_W] = 8'd10;
         send(w, 2'b00, ACC_W'(200));
         send(w, 2'b00, ACC_W'(199));
      end
      drain();

      // stall: downstream ready low for 10 cycles under continuous input
      bus.i_convolved_data_ready = 1'b0;
      acc0 = acc_cnt;
      fork
         begin
            for (int i = 0; i < 8; i++) send_rand();
         end
         begin
            repeat (10) tick();
            check_eq("stall_accepted", 32'(acc_cnt - acc0), 4);
            check_eq("stall_ready", 32'(bus.o_pixel_data_ready), 0);
            bus.i_convolved_data_ready = 1'b1;
         end
      join
      drain();

      // random windows, modes, thresholds and downstream ready
      rand_done = 0;
      fork
         begin
            for (int i = 0; i < 40; i++) send_rand();
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               bus.i_convolved_data_ready = ($urandom_range(0, 3) != 0);
               tick();
            end
         end
      join
      bus.i_convolved_data_ready = 1'b1;
      drain();

      // saturation
      for (int i = 0; i < 20; i++) send(win_col0(255), 2'b10, ACC_W'(4000));
      drain();
      check_eq("sat_count", 32'(bus.o_edge_count), 15);

      // clear wins over a simultaneous edge transfer
      bus.i_convolved_data_ready = 1'b0;
      send(win_col0(255), 2'b10, ACC_W'(4000));
      guard = 0;
      while (!bus.o_convolved_data_valid && guard < 20) begin
         tick();
         guard++;
      end
      check_eq("clr_wait_valid", 32'(bus.o_convolved_data_valid), 1);
      bus.i_convolved_data_ready = 1'b1;
      bus.i_count_clr            = 1'b1;
      tick();
      bus.i_count_clr = 1'b0;
      check_eq("clr_priority", 32'(bus.o_edge_count), 0);
      drain();

      // reset with windows in flight
      send(win_col0(255), 2'b00, ACC_W'(4000));
      send(win_col0(255), 2'b01, ACC_W'(4000));
      drain();
      check_eq("pre_rst_count", 32'(bus.o_edge_count), 2);
      send(win_col0(255), 2'b10, ACC_W'(4000));
      send(win_col0(200), 2'b10, ACC_W'(4000));
      send(win_flat(7),   2'b10, ACC_W'(4000));
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_eq("mid_rst_valid", 32'(bus.o_convolved_data_valid), 0);
      check_eq("mid_rst_count", 32'(bus.o_edge_count), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      check_eq("post_rst_idle", 32'(bus.o_convolved_data_valid), 0);
      send(win_col0(255), 2'b10, ACC_W'(4000));
      measure_latency("latency_after_rst");
      drain();

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
